// File: rtl/ysyx_23060191_pkg.sv
// Shared constants for the ysyx_23060191 execute stage: datapath width,
// ALU opcodes and operand-source selects.
package ysyx_23060191_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [3:0] ADD   = 4'd0;
  localparam logic [3:0] SUB   = 4'd1;
  localparam logic [3:0] AND   = 4'd2;
  localparam logic [3:0] OR    = 4'd3;
  localparam logic [3:0] XOR   = 4'd4;
  localparam logic [3:0] SLL   = 4'd5;
  localparam logic [3:0] SRL   = 4'd6;
  localparam logic [3:0] SRA   = 4'd7;
  localparam logic [3:0] SLT   = 4'd8;
  localparam logic [3:0] SLTU  = 4'd9;
  localparam logic [3:0] PASSB = 4'd10;

  localparam logic [1:0] SEL_RR = 2'b00;
  localparam logic [1:0] SEL_RI = 2'b01;
  localparam logic [1:0] SEL_PI = 2'b10;
  localparam logic [1:0] SEL_P4 = 2'b11;

endpackage

// File: rtl/ysyx_23060191_exu_gpr_if.sv
// Register-file and ALU signal bundle between the decode side (master)
// and the execute/GPR block (slave).
interface ysyx_23060191_exu_gpr_if #(
  parameter int XLEN = ysyx_23060191_pkg::DEFAULT_XLEN
);

  logic            wr_en_Rd;
  logic [4:0]      addr_Rd;
  logic [4:0]      addr_Rs1;
  logic [4:0]      addr_Rs2;
  logic [XLEN-1:0] data_Rd;
  logic [XLEN-1:0] data_Rs1;
  logic [XLEN-1:0] data_Rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [3:0]      exu_opt_code;
  logic [1:0]      exu_sel_code;
  logic [XLEN-1:0] exu_res;
  logic            zero;

  modport master (
    output wr_en_Rd, addr_Rd, addr_Rs1, addr_Rs2, data_Rd, pc, imm,
           exu_opt_code, exu_sel_code,
    input  data_Rs1, data_Rs2, exu_res, zero
  );

  modport slave (
    input  wr_en_Rd, addr_Rd, addr_Rs1, addr_Rs2, data_Rd, pc, imm,
           exu_opt_code, exu_sel_code,
    output data_Rs1, data_Rs2, exu_res, zero
  );

endinterface

// File: rtl/ysyx_23060191_exu_gpr_regfile.sv
// 32-entry general-purpose register file with x0 hard-wired to zero.
// Define GPR_RST_CLR_EN to clear x1..x31 while rst_sync is high.
module ysyx_23060191_regfile
  import ysyx_23060191_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_sync,
  input  logic            wr_en_Rd,
  input  logic [4:0]      addr_Rd,
  input  logic [4:0]      addr_Rs1,
  input  logic [4:0]      addr_Rs2,
  input  logic [XLEN-1:0] data_Rd,
  output logic [XLEN-1:0] data_Rs1,
  output logic [XLEN-1:0] data_Rs2
);

  logic [XLEN-1:0] regs [1:31];

`ifdef GPR_RST_CLR_EN
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wr_en_Rd && (addr_Rd != 5'd0)) begin
      regs[addr_Rd] <= data_Rd;
    end
  end
`else
  // Contents deliberately survive reset; only the write is blocked.
  always_ff @(posedge clk) begin
    if (!rst_sync && wr_en_Rd && (addr_Rd != 5'd0)) begin
      regs[addr_Rd] <= data_Rd;
    end
  end
`endif

  // No write bypass: a read of the register being written sees the old value.
  assign data_Rs1 = (addr_Rs1 == 5'd0) ? '0 : regs[addr_Rs1];
  assign data_Rs2 = (addr_Rs2 == 5'd0) ? '0 : regs[addr_Rs2];

endmodule

// File: rtl/ysyx_23060191_exu_gpr.sv
// Execute stage: GPR file, one-cycle reset delay and combinational ALU.
// Optional macro GPR_RST_CLR_EN clears the register file during reset.
module ysyx_23060191_exu_gpr
  import ysyx_23060191_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rst_sync,
  ysyx_23060191_exu_gpr_if.slave   bus
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] res;

  always_ff @(posedge clk) begin
    rst_sync <= rst;
  end

  ysyx_23060191_regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_sync (rst_sync),
    .wr_en_Rd (bus.wr_en_Rd),
    .addr_Rd  (bus.addr_Rd),
    .addr_Rs1 (bus.addr_Rs1),
    .addr_Rs2 (bus.addr_Rs2),
    .data_Rd  (bus.data_Rd),
    .data_Rs1 (bus.data_Rs1),
    .data_Rs2 (bus.data_Rs2)
  );

  always_comb begin
    op_a = bus.data_Rs1;
    op_b = bus.data_Rs2;
    unique case (bus.exu_sel_code)
      SEL_RR: begin op_a = bus.data_Rs1; op_b = bus.data_Rs2; end
      SEL_RI: begin op_a = bus.data_Rs1; op_b = bus.imm;      end
      SEL_PI: begin op_a = bus.pc;       op_b = bus.imm;      end
      SEL_P4: begin op_a = bus.pc;       op_b = XLEN'(4);     end
      default: ;
    endcase
  end

  assign shamt = op_b[4:0];

  // Unused opcodes 11..15 fall through to zero.
  always_comb begin
    res = '0;
    case (bus.exu_opt_code)
      ADD:   res = op_a + op_b;
      SUB:   res = op_a - op_b;
      AND:   res = op_a & op_b;
      OR:    res = op_a | op_b;
      XOR:   res = op_a ^ op_b;
      SLL:   res = op_a << shamt;
      SRL:   res = op_a >> shamt;
      SRA:   res = $signed(op_a) >>> shamt;
      SLT:   res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      SLTU:  res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      PASSB: res = op_b;
      default: res = '0;
    endcase
  end

  assign bus.exu_res = res;
  assign bus.zero    = (res == '0);

endmodule

// File: tb/tb_ysyx_23060191_exu_gpr.sv
// Self-checking bench for ysyx_23060191_exu_gpr: directed corner cases then
// randomized traffic checked against an array-based reference model.
module tb_ysyx_23060191_exu_gpr;
  import ysyx_23060191_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_sync;

  int numChecks = 0;
  int numPass   = 0;
  int numFail   = 0;

  // reference state: register values, which ones have a defined value, reset delay
  logic [31:0] mdlReg   [32];
  bit          mdlKnown [32];
  logic        mdlRstSync;

  ysyx_23060191_exu_gpr_if #(.XLEN(32)) bus ();

  ysyx_23060191_exu_gpr #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      numPass++;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [4:0] rd, input logic [31:0] wdata,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [3:0] op, input logic [1:0] sel,
                               input logic [31:0] pcv, input logic [31:0] immv);
    bus.wr_en_Rd     = wr;
    bus.addr_Rd      = rd;
    bus.data_Rd      = wdata;
    bus.addr_Rs1     = rs1;
    bus.addr_Rs2     = rs2;
    bus.exu_opt_code = op;
    bus.exu_sel_code = sel;
    bus.pc           = pcv;
    bus.imm          = immv;
    #2;
  endtask

  // Advance one clock edge and apply the architectural effect to the model.
  task automatic tick();
    logic        wr   = bus.wr_en_Rd;
    logic [4:0]  rd   = bus.addr_Rd;
    logic [31:0] wd   = bus.data_Rd;
    logic        rsIn = rst;
    @(posedge clk);
    #1;
`ifdef GPR_RST_CLR_EN
    if (mdlRstSync === 1'b1) begin
      for (int i = 1; i < 32; i++) begin mdlReg[i] = 32'd0; mdlKnown[i] = 1'b1; end
    end
`endif
    if (wr && mdlRstSync === 1'b0 && rd != 5'd0) begin
      mdlReg[rd]   = wd;
      mdlKnown[rd] = 1'b1;
    end
    mdlRstSync = rsIn;
  endtask

  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    int              sh = int'(b % 32);
    case (op)
      4'd0:  return 32'((ua + ub) % 64'h1_0000_0000);
      4'd1:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd6:  return 32'(ua / (64'd1 << sh));
      4'd7:  return 32'((sa - ((sa % (64'sd1 << sh) + (64'sd1 << sh)) % (64'sd1 << sh))) / (64'sd1 << sh));
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic writeReg(input logic [4:0] rd, input logic [31:0] val);
    applyStimulus(1'b1, rd, val, 5'd0, 5'd0, ADD, SEL_RR, 32'd0, 32'd0);
    tick();
  endtask

  task automatic checkAlu(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [3:0] op, input logic [1:0] sel,
                          input logic [31:0] pcv, input logic [31:0] immv, input logic [31:0] exp);
    applyStimulus(1'b0, 5'd0, 32'd0, rs1, rs2, op, sel, pcv, immv);
    checkOutput(tag, bus.exu_res, exp);
    checkOutput({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    logic [31:0] a, b, expRes;
    logic [3:0]  op;
    logic [1:0]  sel;
    bit          aKnown, bKnown;

    for (int i = 0; i < 32; i++) begin mdlReg[i] = 32'd0; mdlKnown[i] = (i == 0); end
    mdlRstSync = 1'bx;
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, ADD, SEL_RR, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_sync_idle", {31'd0, rst_sync}, 32'd0);

    // reset timing with a value parked in x5 beforehand
    writeReg(5'd5, 32'h1234);
    rst = 1'b1;
    applyStimulus(1'b1, 5'd7, 32'hAAAA_5555, 5'd5, 5'd0, ADD, SEL_RR, 32'd0, 32'd0);
    tick();
    checkOutput("rst_sync_rise", {31'd0, rst_sync}, 32'd1);
    tick();
    checkOutput("rst_sync_hold", {31'd0, rst_sync}, 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("rst_sync_fall", {31'd0, rst_sync}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, ADD, SEL_RR, 32'd0, 32'd0);
`ifdef GPR_RST_CLR_EN
    checkOutput("x5_after_reset", bus.data_Rs1, 32'd0);
`else
    checkOutput("x5_after_reset", bus.data_Rs1, 32'h1234);
`endif
    if (mdlKnown[7]) checkOutput("x7_write_in_reset", bus.data_Rs2, mdlReg[7]);

    // write/read ordering and x0
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, ADD, SEL_RR, 32'd0, 32'd0);
    checkOutput("x5_same_cycle_old", bus.data_Rs1, mdlReg[5]);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, ADD, SEL_RR, 32'd0, 32'd0);
    checkOutput("x5_next_cycle", bus.data_Rs1, 32'hDEAD_BEEF);
    writeReg(5'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, ADD, SEL_RR, 32'd0, 32'd0);
    checkOutput("x0_reads_zero", bus.data_Rs1, 32'd0);

    // directed ALU corners
    writeReg(5'd1, 32'h7FFF_FFFF);
    writeReg(5'd2, 32'd1);
    writeReg(5'd3, 32'd7);
    writeReg(5'd4, 32'h8000_0000);
    writeReg(5'd6, 32'hFFFF_FFFF);
    checkAlu("add_wrap",   5'd1, 5'd2, ADD,   SEL_RR, 32'd0, 32'd0, 32'h8000_0000);
    checkAlu("sub_zero",   5'd3, 5'd3, SUB,   SEL_RR, 32'd0, 32'd0, 32'd0);
    checkAlu("sra",        5'd4, 5'd0, SRA,   SEL_RI, 32'd0, 32'h21, 32'hC000_0000);
    checkAlu("srl",        5'd4, 5'd0, SRL,   SEL_RI, 32'd0, 32'h21, 32'h4000_0000);
    checkAlu("sll",        5'd4, 5'd0, SLL,   SEL_RI, 32'd0, 32'h21, 32'd0);
    checkAlu("slt",        5'd6, 5'd2, SLT,   SEL_RR, 32'd0, 32'd0, 32'd1);
    checkAlu("sltu",       5'd6, 5'd2, SLTU,  SEL_RR, 32'd0, 32'd0, 32'd0);
    checkAlu("pc_plus4",   5'd0, 5'd0, ADD,   SEL_P4, 32'h8000_0000, 32'd0, 32'h8000_0004);
    checkAlu("pc_imm",     5'd0, 5'd0, ADD,   SEL_PI, 32'h8000_0000, 32'hFFFF_FFFC, 32'h7FFF_FFFC);
    checkAlu("passb",      5'd0, 5'd0, PASSB, SEL_PI, 32'h8000_0000, 32'h1234_5000, 32'h1234_5000);
    checkAlu("op_unused",  5'd6, 5'd6, 4'd13, SEL_RR, 32'd0, 32'd0, 32'd0);

    // randomized traffic, with an occasional mid-run reset
    for (int r = 1; r < 32; r++) writeReg(5'(r), $urandom);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      op  = 4'($urandom_range(0, 15));
      sel = 2'($urandom);
      applyStimulus(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), op, sel,
                    $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      if (mdlKnown[bus.addr_Rs1]) checkOutput("rnd_rs1", bus.data_Rs1, mdlReg[bus.addr_Rs1]);
      if (mdlKnown[bus.addr_Rs2]) checkOutput("rnd_rs2", bus.data_Rs2, mdlReg[bus.addr_Rs2]);
      aKnown = sel[1] || mdlKnown[bus.addr_Rs1];
      bKnown = (sel != SEL_RR) || mdlKnown[bus.addr_Rs2];
      if (aKnown && bKnown) begin
        a = sel[1] ? bus.pc : mdlReg[bus.addr_Rs1];
        b = (sel == SEL_RR) ? mdlReg[bus.addr_Rs2] : (sel == SEL_P4) ? 32'd4 : bus.imm;
        expRes = refAlu(op, a, b);
        checkOutput("rnd_res", bus.exu_res, expRes);
        checkOutput("rnd_zero", {31'd0, bus.zero}, {31'd0, expRes == 32'd0});
      end
      tick();
      checkOutput("rnd_rst_sync", {31'd0, rst_sync}, {31'd0, mdlRstSync});
    end

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060191_exu_gpr.md
YSYX_23060191_EXU_GPR -- requirements
Module: ysyx_23060191_exu_gpr

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address-path width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst_sync  output  1  rst delayed one clk cycle.
REQ-005 SHALL have port wr_en_Rd  input  1  register write enable.
REQ-006 SHALL have port addr_Rd, addr_Rs1, addr_Rs2  input  5 each  write and read register indices.
REQ-007 SHALL have port data_Rd  input  XLEN  write data.
REQ-008 SHALL have port data_Rs1, data_Rs2  output  XLEN  read data.
REQ-009 SHALL have port pc, imm  input  XLEN  program counter and sign-extended immediate.
REQ-010 SHALL have port exu_opt_code  input  4  ALU operation select.
REQ-011 SHALL have port exu_sel_code  input  2  operand source select.
REQ-012 SHALL have port exu_res  output  XLEN  ALU result.
REQ-013 SHALL have port zero  output  1  ALU result equals zero.

Function
REQ-014 SHALL register rst into rst_sync every rising edge, so rst_sync is exactly one cycle later.
REQ-015 SHALL hold 32 registers x0..x31; x0 always reads 0, and writes to x0 are discarded.
REQ-016 SHALL read data_Rs1/data_Rs2 combinationally from addr_Rs1/addr_Rs2.
REQ-017 SHALL write data_Rd to addr_Rd on a rising edge when wr_en_Rd=1 and rst_sync=0.
REQ-018 SHALL NOT bypass writes: a same-cycle read of addr_Rd returns the old value, and the new value appears after the edge.
REQ-019 SHALL select operands by exu_sel_code: 00 A=Rs1,B=Rs2; 01 A=Rs1,B=imm; 10 A=pc,B=imm; 11 A=pc,B=4.
REQ-020 SHALL compute exu_res combinationally from exu_opt_code as follows.
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
- 5 SLL, 6 SRL, 7 SRA, each using shift amount B[4:0].
- 8 SLT (signed, result 1/0); 9 SLTU (unsigned, result 1/0).
- 10 PASSB (B).
- 11..15 SHALL produce 0.
REQ-021 SHALL make ADD/SUB wrap modulo 2^XLEN with no overflow flag.
REQ-022 SHALL drive zero=1 iff exu_res==0, for every opcode.

Reset
REQ-023 SHALL drive rst_sync=1 on the first edge with rst=1, and drive rst_sync=0 one edge after rst falls.
REQ-024 SHALL ignore register writes while rst_sync=1, including a reset asserted mid-operation.
REQ-025 SHALL keep the EXU purely combinational and unaffected by reset.

Configuration
REQ-026 SHALL support macro GPR_RST_CLR_EN.
- Defined: x1..x31 are cleared to 0 on any edge with rst_sync=1.
- Undefined: register contents survive reset, and their power-up value is undefined.

Structure
REQ-027 SHALL place XLEN default, opcode constants (ADD..PASSB), operand-select constants (SEL_RR, SEL_RI, SEL_PI, SEL_P4) in shared package ysyx_23060191_pkg.
REQ-028 SHALL implement the register file as sub-module ysyx_23060191_regfile; the ALU and reset delay are inline.

Verification
REQ-029 SHALL cover reset timing: rst=1 for 2 cycles then 0 -> rst_sync high 1 cycle later and low 1 cycle after rst falls; with GPR_RST_CLR_EN, a prior x5=0x1234 reads 0.
REQ-030 SHALL cover register write/read: write x5=0xDEADBEEF, read the same cycle -> old value; next cycle data_Rs1=0xDEADBEEF; write x0=0xFFFFFFFF -> x0 reads 0.
REQ-031 SHALL cover arithmetic: Rs1=0x7FFFFFFF, Rs2=1, sel=00.
- ADD -> 0x80000000, zero=0.
- SUB with Rs1=Rs2=7 -> 0, zero=1.
REQ-032 SHALL cover shifts: Rs1=0x80000000, imm=0x21 (shift amount 1), sel=01.
- SRA -> 0xC0000000.
- SRL -> 0x40000000.
- SLL -> 0.
REQ-033 SHALL cover compares: Rs1=0xFFFFFFFF, Rs2=1.
- SLT -> 1.
- SLTU -> 0.
REQ-034 SHALL cover pc operands: pc=0x80000000.
- sel=11 ADD -> 0x80000004.
- sel=10, imm=0xFFFFFFFC ADD -> 0x7FFFFFFC.
- PASSB, imm=0x12345000 -> 0x12345000.
